// File: rtl/rf_wb_sched.sv
// rf_wb_sched
// Write-back scheduler for the core's single-write-port register file.
// The pipeline write-back stage and the AHB load-return path share one
// register-file write port. Load returns are buffered in a small FIFO. A
// per-register scoreboard of loads in flight drives the decode RAW/WAW stall.
//
// Parameters:
//   LQ_DEPTH      load-return queue entries (power of two, >= 2)
//   STARVE_LIMIT  cycles a queued load may wait before it forces a pipeline hold
//
// Ports:
//   i_clk            clock; all state changes on the rising edge
//   i_reset_n        asynchronous active-low reset
//   i_pw_valid/rd/data   pipeline write-back request
//   o_pipe_hold      pipeline must hold its WB instruction and re-present it
//   i_lr_valid/rd/data   AHB load data return
//   o_lr_ready       the queue can accept load data
//   i_ld_issue/ld_rd decode issues a load to ld_rd
//   i_id_valid/rs1/rs2/rd  decode instruction register selects
//   o_id_stall       decode must stall on a pending load hazard
//   o_rf_reg_write/rd_sel/wb_data  register-file write port
module rf_wb_sched #(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pw_valid,
  input  logic [4:0]  i_pw_rd,
  input  logic [31:0] i_pw_data,
  output logic        o_pipe_hold,
  input  logic        i_lr_valid,
  output logic        o_lr_ready,
  input  logic [4:0]  i_lr_rd,
  input  logic [31:0] i_lr_data,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_rd,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_id_rd,
  output logic        o_id_stall,
  output logic        o_rf_reg_write,
  output logic [4:0]  o_rf_rd_sel,
  output logic [31:0] o_rf_wb_data
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_lq_rd   [LQ_DEPTH];
  logic [31:0]   r_lq_data [LQ_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_starve;
  logic          r_force_q;
  logic [31:0]   r_pending;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_grant_q;
  logic          w_grant_p;
  logic          w_force_grant;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [7:0]    w_starve_next;
  logic          w_force_set;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_eff;

  assign w_full      = (r_count == CW'(LQ_DEPTH));
  assign w_empty     = (r_count == '0);
  assign o_lr_ready  = !w_full;
  assign w_push      = i_lr_valid & !w_full;
  assign w_head_rd   = r_lq_rd[r_rd_ptr];
  assign w_head_data = r_lq_data[r_rd_ptr];

  // A forced grant takes the port from the pipeline regardless of pw_valid.
  // The pipeline grant is gated by reset so the write port stays quiet
  // while reset is asserted, even if the pipeline is presenting a write.
  assign w_force_grant = r_force_q & !w_empty;
  assign w_grant_q     = !w_empty & (r_force_q | !i_pw_valid);
  assign w_grant_p     = i_reset_n & i_pw_valid & !w_force_grant;
  assign o_pipe_hold   = w_force_grant;

  // rd=0 grants still consume their source but never strobe the write.
  always_comb begin
    o_rf_reg_write = 1'b0;
    o_rf_rd_sel    = 5'd0;
    o_rf_wb_data   = 32'd0;
    if (w_grant_q) begin
      o_rf_reg_write = (w_head_rd != 5'd0);
      o_rf_rd_sel    = w_head_rd;
      o_rf_wb_data   = w_head_data;
    end else if (w_grant_p) begin
      o_rf_reg_write = (i_pw_rd != 5'd0);
      o_rf_rd_sel    = i_pw_rd;
      o_rf_wb_data   = i_pw_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_lq_rd[i]   <= 5'd0;
        r_lq_data[i] <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_lq_rd[r_wr_ptr]   <= i_lr_rd;
        r_lq_data[r_wr_ptr] <= i_lr_data;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_grant_q) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_grant_q})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts cycles the head waits without a grant; saturates rather than wraps.
  always_comb begin
    w_starve_next = 8'd0;
    if (!w_empty && !w_grant_q) begin
      w_starve_next = (r_starve == 8'hFF) ? r_starve : r_starve + 8'd1;
    end
  end

  assign w_force_set = !w_empty &&
                       ((w_starve_next == 8'(STARVE_LIMIT)) || (w_full && i_pw_valid));

  // Clearing after a forced grant takes priority over re-arming, so one
  // force event drains exactly one entry even if the queue was full.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve  <= 8'd0;
      r_force_q <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      if (w_force_grant || w_empty) begin
        r_force_q <= 1'b0;
      end else if (w_force_set) begin
        r_force_q <= 1'b1;
      end
    end
  end

  assign w_clr_mask = (w_grant_q && (w_head_rd != 5'd0)) ? (32'd1 << w_head_rd) : 32'd0;
  assign w_set_mask = (i_ld_issue && (i_ld_rd != 5'd0)) ? (32'd1 << i_ld_rd) : 32'd0;

  // Set after clear so a same-cycle reissue to the same register wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end
  end

  // The register being written this cycle no longer stalls decode; the
  // register-file read bypass supplies its value.
  assign w_eff      = r_pending & ~w_clr_mask;
  assign o_id_stall = i_id_valid & (w_eff[i_id_rs1] | w_eff[i_id_rs2] | w_eff[i_id_rd]);

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed testbench for rf_wb_sched (LQ_DEPTH=4, STARVE_LIMIT=8).
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pw_valid;
  logic [4:0]  pw_rd;
  logic [31:0] pw_data;
  logic        pipe_hold;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        rf_reg_write;
  logic [4:0]  rf_rd_sel;
  logic [31:0] rf_wb_data;
  logic [37:0] wbObs;

  int errorCount = 0;
  int checkCount = 0;

  assign wbObs = {rf_reg_write, rf_rd_sel, rf_wb_data};

  always #5 clk = ~clk;

  rf_wb_sched #(.LQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_pw_valid(pw_valid), .i_pw_rd(pw_rd), .i_pw_data(pw_data),
    .o_pipe_hold(pipe_hold),
    .i_lr_valid(lr_valid), .o_lr_ready(lr_ready), .i_lr_rd(lr_rd), .i_lr_data(lr_data),
    .i_ld_issue(ld_issue), .i_ld_rd(ld_rd),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .o_id_stall(id_stall),
    .o_rf_reg_write(rf_reg_write), .o_rf_rd_sel(rf_rd_sel), .o_rf_wb_data(rf_wb_data)
  );

  task automatic clearInputs();
    pw_valid = 0; pw_rd = 0; pw_data = 0;
    lr_valid = 0; lr_rd = 0; lr_data = 0;
    ld_issue = 0; ld_rd = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    reset_n = 0;
    pw_valid = 1; pw_rd = 3; pw_data = 32'h1;
    id_valid = 1; id_rs1 = 5;
    #3;
    checkCount++;
    if ({lr_ready, pipe_hold, id_stall} !== 3'b100) begin
      errorCount++; $display("[TB] FAIL reset_flags: got %b expected 100", {lr_ready, pipe_hold, id_stall});
    end
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL reset_wb: got %h expected 0", wbObs);
    end
    clearInputs();
    nextCycle();
    reset_n = 1;
    #4;
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL reset_idle_wb: got %h expected 0", wbObs);
    end
  endtask

  task automatic test_load_basic();
    nextCycle();
    lr_valid = 1; lr_rd = 5; lr_data = 32'hDEADBEEF;
    #4;
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL load_no_bypass: got %h expected 0", wbObs);
    end
    checkCount++;
    if (lr_ready !== 1'b1) begin
      errorCount++; $display("[TB] FAIL load_ready: got %b expected 1", lr_ready);
    end
    nextCycle();
    lr_valid = 0;
    #4;
    checkCount++;
    if (wbObs !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errorCount++; $display("[TB] FAIL load_write: got %h expected %h", wbObs, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    nextCycle();
    #4;
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL load_empty_after: got %h expected 0", wbObs);
    end
  endtask

  task automatic test_pipe_pass();
    nextCycle();
    pw_valid = 1; pw_rd = 3; pw_data = 32'h12345678;
    #4;
    checkCount++;
    if (wbObs !== {1'b1, 5'd3, 32'h12345678}) begin
      errorCount++; $display("[TB] FAIL pipe_pass: got %h expected %h", wbObs, {1'b1, 5'd3, 32'h12345678});
    end
    checkCount++;
    if (pipe_hold !== 1'b0) begin
      errorCount++; $display("[TB] FAIL pipe_hold_idle: got %b expected 0", pipe_hold);
    end
    pw_rd = 0; pw_data = 32'hFFFF;
    #1;
    checkCount++;
    if (rf_reg_write !== 1'b0) begin
      errorCount++; $display("[TB] FAIL pipe_rd0: got %b expected 0", rf_reg_write);
    end
    clearInputs();
  endtask

  task automatic test_starve();
    logic [37:0] expWb;
    logic        expHold;
    nextCycle();
    pw_valid = 1; pw_rd = 10; pw_data = 32'hA0A0A0A0;
    lr_valid = 1; lr_rd = 9; lr_data = 32'h99;
    #4;
    checkCount++;
    if (pipe_hold !== 1'b0) begin
      errorCount++; $display("[TB] FAIL starve_c0_hold: got %b expected 0", pipe_hold);
    end
    for (int k = 1; k <= 10; k++) begin
      nextCycle();
      lr_valid = 0;
      #4;
      expHold = (k == 9);
      expWb   = (k == 9) ? {1'b1, 5'd9, 32'h99} : {1'b1, 5'd10, 32'hA0A0A0A0};
      checkCount++;
      if (pipe_hold !== expHold) begin
        errorCount++; $display("[TB] FAIL starve_hold c%0d: got %b expected %b", k, pipe_hold, expHold);
      end
      checkCount++;
      if (wbObs !== expWb) begin
        errorCount++; $display("[TB] FAIL starve_wb c%0d: got %h expected %h", k, wbObs, expWb);
      end
    end
    clearInputs();
  endtask

  task automatic test_full_force();
    nextCycle();
    pw_valid = 1; pw_rd = 11; pw_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) nextCycle();
      lr_valid = 1; lr_rd = 5'(12 + k); lr_data = 32'(32'hC0 + k);
      #4;
      checkCount++;
      if (lr_ready !== 1'b1) begin
        errorCount++; $display("[TB] FAIL fill_ready c%0d: got %b expected 1", k, lr_ready);
      end
    end
    nextCycle();
    lr_valid = 0;
    #4;
    checkCount++;
    if ({lr_ready, pipe_hold} !== 2'b00) begin
      errorCount++; $display("[TB] FAIL full_flags: got %b expected 00", {lr_ready, pipe_hold});
    end
    nextCycle();
    #4;
    checkCount++;
    if ({lr_ready, pipe_hold} !== 2'b01) begin
      errorCount++; $display("[TB] FAIL force_flags: got %b expected 01", {lr_ready, pipe_hold});
    end
    checkCount++;
    if (wbObs !== {1'b1, 5'd12, 32'hC0}) begin
      errorCount++; $display("[TB] FAIL force_wb: got %h expected %h", wbObs, {1'b1, 5'd12, 32'hC0});
    end
    nextCycle();
    #4;
    checkCount++;
    if ({lr_ready, pipe_hold} !== 2'b10) begin
      errorCount++; $display("[TB] FAIL after_force_flags: got %b expected 10", {lr_ready, pipe_hold});
    end
    checkCount++;
    if (wbObs !== {1'b1, 5'd11, 32'hB}) begin
      errorCount++; $display("[TB] FAIL after_force_wb: got %h expected %h", wbObs, {1'b1, 5'd11, 32'hB});
    end
    for (int k = 1; k < 4; k++) begin
      nextCycle();
      pw_valid = 0;
      #4;
      checkCount++;
      if (wbObs !== {1'b1, 5'(12 + k), 32'(32'hC0 + k)}) begin
        errorCount++; $display("[TB] FAIL drain_wb %0d: got %h expected %h", k, wbObs, {1'b1, 5'(12 + k), 32'(32'hC0 + k)});
      end
    end
    nextCycle();
    #4;
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL drain_empty: got %h expected 0", wbObs);
    end
    clearInputs();
  endtask

  task automatic test_scoreboard();
    nextCycle();
    ld_issue = 1; ld_rd = 7; id_valid = 1; id_rs1 = 7;
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL sb_issue_cycle: got %b expected 0", id_stall);
    end
    nextCycle();
    ld_issue = 0;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL sb_rs1: got %b expected 1", id_stall);
    end
    nextCycle();
    id_rs1 = 0; id_rs2 = 7;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL sb_rs2: got %b expected 1", id_stall);
    end
    nextCycle();
    id_rs2 = 0; id_rd = 7;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL sb_rd: got %b expected 1", id_stall);
    end
    nextCycle();
    id_valid = 0;
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL sb_invalid: got %b expected 0", id_stall);
    end
    nextCycle();
    id_valid = 1; id_rd = 0; id_rs1 = 7;
    lr_valid = 1; lr_rd = 7; lr_data = 32'h77;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL sb_accept_cycle: got %b expected 1", id_stall);
    end
    nextCycle();
    lr_valid = 0;
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL sb_bypass: got %b expected 0", id_stall);
    end
    checkCount++;
    if (wbObs !== {1'b1, 5'd7, 32'h77}) begin
      errorCount++; $display("[TB] FAIL sb_grant_wb: got %h expected %h", wbObs, {1'b1, 5'd7, 32'h77});
    end
    nextCycle();
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL sb_cleared: got %b expected 0", id_stall);
    end
    clearInputs();
  endtask

  task automatic test_set_wins();
    nextCycle();
    ld_issue = 1; ld_rd = 8;
    nextCycle();
    ld_issue = 0; lr_valid = 1; lr_rd = 8; lr_data = 32'h88; id_valid = 1; id_rs1 = 8;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL setwin_pending: got %b expected 1", id_stall);
    end
    nextCycle();
    lr_valid = 0; ld_issue = 1; ld_rd = 8;
    #4;
    checkCount++;
    if ({id_stall, wbObs} !== {1'b0, 1'b1, 5'd8, 32'h88}) begin
      errorCount++; $display("[TB] FAIL setwin_grant: got %h expected %h", {id_stall, wbObs}, {1'b0, 1'b1, 5'd8, 32'h88});
    end
    nextCycle();
    ld_issue = 0; lr_valid = 1; lr_rd = 8; lr_data = 32'h89;
    #4;
    checkCount++;
    if (id_stall !== 1'b1) begin
      errorCount++; $display("[TB] FAIL setwin_kept: got %b expected 1", id_stall);
    end
    nextCycle();
    lr_valid = 0;
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL setwin_second_grant: got %b expected 0", id_stall);
    end
    nextCycle();
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL setwin_cleared: got %b expected 0", id_stall);
    end
    clearInputs();
  endtask

  task automatic test_rd_zero();
    nextCycle();
    ld_issue = 1; ld_rd = 0;
    nextCycle();
    ld_issue = 0; id_valid = 1;
    lr_valid = 1; lr_rd = 0; lr_data = 32'h55;
    #4;
    checkCount++;
    if (id_stall !== 1'b0) begin
      errorCount++; $display("[TB] FAIL rd0_no_stall: got %b expected 0", id_stall);
    end
    nextCycle();
    lr_rd = 4; lr_data = 32'h44;
    #4;
    checkCount++;
    if (rf_reg_write !== 1'b0) begin
      errorCount++; $display("[TB] FAIL rd0_no_write: got %b expected 0", rf_reg_write);
    end
    nextCycle();
    lr_valid = 0;
    #4;
    checkCount++;
    if (wbObs !== {1'b1, 5'd4, 32'h44}) begin
      errorCount++; $display("[TB] FAIL rd0_popped: got %h expected %h", wbObs, {1'b1, 5'd4, 32'h44});
    end
    nextCycle();
    #4;
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL rd0_empty: got %h expected 0", wbObs);
    end
    clearInputs();
  endtask

  task automatic test_reset_mid();
    nextCycle();
    pw_valid = 1; pw_rd = 1; pw_data = 32'h11;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) nextCycle();
      ld_issue = 1; ld_rd = 5'(5 + k);
      lr_valid = 1; lr_rd = 5'(20 + k); lr_data = 32'(k);
    end
    nextCycle();
    ld_issue = 0; lr_valid = 0;
    id_valid = 1; id_rs1 = 5; id_rs2 = 6; id_rd = 7;
    #4;
    checkCount++;
    if ({lr_ready, pipe_hold, id_stall} !== 3'b101) begin
      errorCount++; $display("[TB] FAIL pre_reset_flags: got %b expected 101", {lr_ready, pipe_hold, id_stall});
    end
    #1;
    reset_n = 0;
    #1;
    checkCount++;
    if ({lr_ready, pipe_hold, id_stall} !== 3'b100) begin
      errorCount++; $display("[TB] FAIL mid_reset_flags: got %b expected 100", {lr_ready, pipe_hold, id_stall});
    end
    checkCount++;
    if (wbObs !== 38'd0) begin
      errorCount++; $display("[TB] FAIL mid_reset_wb: got %h expected 0", wbObs);
    end
    nextCycle();
    reset_n = 1; pw_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #4;
      checkCount++;
      if ({id_stall, wbObs} !== 39'd0) begin
        errorCount++; $display("[TB] FAIL post_reset c%0d: got %h expected 0", k, {id_stall, wbObs});
      end
      nextCycle();
    end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_pipe_pass();
    test_starve();
    test_full_force();
    test_scoreboard();
    test_set_wins();
    test_rd_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
